// File: rtl/wb_demux_2.sv
// -----------------------------------------------------------------------------
// wb_demux_2 -- Wishbone classic 1-master to 2-slave demultiplexer.
//
// The address of each new access is decoded once in IDLE, and the result is
// registered into sel_q. The strobe and cycle are then routed to the selected
// slave for the rest of the access. An address that matches neither region
// gets a one-cycle decode error, and no slave is strobed. Slave 0 wins when
// both regions match.
//
// Optional feature (compile-time macro WB_DEMUX_TIMEOUT_EN):
//   When defined, a watchdog counts ACTIVE cycles that have no termination.
//   On the cycle where tmo_cnt == TIMEOUT_CYCLES-1:
//     - the slave cyc/stb are forced low,
//     - the master receives err,
//     - the FSM returns to IDLE.
//   When undefined, ACTIVE waits indefinitely for a slave termination.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   wbm_*               master-side Wishbone (adr/dat/we/sel/stb/cyc in,
//                       dat/ack/err/rty out)
//   wbs0_*, wbs1_*      slave-side Wishbone:
//                         - adr/dat/we/sel are broadcast to both slaves
//                         - cyc/stb go only to the selected slave
//                         - dat/ack/err/rty come back from the slaves
// -----------------------------------------------------------------------------
module wb_demux_2 #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] SLAVE0_ADDR    = '0,
    parameter logic [ADDR_WIDTH-1:0] SLAVE0_MASK    = '0,
    parameter logic [ADDR_WIDTH-1:0] SLAVE1_ADDR    = '0,
    parameter logic [ADDR_WIDTH-1:0] SLAVE1_MASK    = '0,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic                    wbm_stb_i,
    output logic                    wbm_ack_o,
    output logic                    wbm_err_o,
    output logic                    wbm_rty_o,
    input  logic                    wbm_cyc_i,

    output logic [ADDR_WIDTH-1:0]   wbs0_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs0_dat_o,
    output logic                    wbs0_we_o,
    output logic [SELECT_WIDTH-1:0] wbs0_sel_o,
    output logic                    wbs0_stb_o,
    output logic                    wbs0_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wbs0_dat_i,
    input  logic                    wbs0_ack_i,
    input  logic                    wbs0_err_i,
    input  logic                    wbs0_rty_i,

    output logic [ADDR_WIDTH-1:0]   wbs1_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs1_dat_o,
    output logic                    wbs1_we_o,
    output logic [SELECT_WIDTH-1:0] wbs1_sel_o,
    output logic                    wbs1_stb_o,
    output logic                    wbs1_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wbs1_dat_i,
    input  logic                    wbs1_ack_i,
    input  logic                    wbs1_err_i,
    input  logic                    wbs1_rty_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DECERR = 2'd2
    } state_t;

    state_t state;
    logic   sel_q;

    // ------------------------------------------------------------------
    // Address decode, used only in IDLE when a new request is seen.
    // ------------------------------------------------------------------
    logic match0, match1, req;

    assign match0 = ((wbm_adr_i & SLAVE0_MASK) == SLAVE0_ADDR);
    assign match1 = ((wbm_adr_i & SLAVE1_MASK) == SLAVE1_ADDR);
    assign req    = wbm_cyc_i & wbm_stb_i;

    // ------------------------------------------------------------------
    // Return path from the selected slave.
    // ------------------------------------------------------------------
    logic                  s_ack, s_err, s_rty;
    logic [DATA_WIDTH-1:0] s_dat;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path can leave it unassigned and infer a latch.
        s_ack = 1'b0;
        s_err = 1'b0;
        s_rty = 1'b0;
        s_dat = '0;
        if (sel_q) begin
            s_ack = wbs1_ack_i;
            s_err = wbs1_err_i;
            s_rty = wbs1_rty_i;
            s_dat = wbs1_dat_i;
        end else begin
            s_ack = wbs0_ack_i;
            s_err = wbs0_err_i;
            s_rty = wbs0_rty_i;
            s_dat = wbs0_dat_i;
        end
    end

    logic in_active;
    logic live;        // ACTIVE with the master still holding the cycle
    logic slave_term;  // selected slave is terminating this cycle
    logic tmo_fire;    // watchdog expires this cycle (always 0 without the feature)

    assign in_active  = (state == ACTIVE);
    assign live       = in_active & wbm_cyc_i;
    assign slave_term = live & (s_ack | s_err | s_rty);

`ifdef WB_DEMUX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_fire = live & ~slave_term & (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // ACTIVE can only be entered from IDLE, so clearing outside ACTIVE is
    // the same as clearing on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (!in_active) begin
            tmo_cnt <= '0;
        end else if (!slave_term) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Slave-side outputs.
    // cyc/stb are gated combinationally by the master's cyc, so an abort
    // drops them in the same cycle. A firing watchdog also gates them off.
    // ------------------------------------------------------------------
    logic route;

    assign route = live & ~tmo_fire;

    assign wbs0_cyc_o = route & ~sel_q;
    assign wbs0_stb_o = route & ~sel_q & wbm_stb_i;
    assign wbs1_cyc_o = route &  sel_q;
    assign wbs1_stb_o = route &  sel_q & wbm_stb_i;

    assign wbs0_adr_o = wbm_adr_i;
    assign wbs0_dat_o = wbm_dat_i;
    assign wbs0_we_o  = wbm_we_i;
    assign wbs0_sel_o = wbm_sel_i;
    assign wbs1_adr_o = wbm_adr_i;
    assign wbs1_dat_o = wbm_dat_i;
    assign wbs1_we_o  = wbm_we_i;
    assign wbs1_sel_o = wbm_sel_i;

    // ------------------------------------------------------------------
    // Master-side outputs.
    // Terminations pass through in the same cycle, and only while live.
    // Stray terminations are therefore dropped:
    //   - in IDLE or DECERR,
    //   - after an abort,
    //   - from the unselected slave (excluded by the sel_q mux).
    // ------------------------------------------------------------------
    assign wbm_ack_o = live & s_ack;
    assign wbm_rty_o = live & s_rty;
    assign wbm_err_o = (live & s_err) | tmo_fire | ((state == DECERR) & req);
    assign wbm_dat_o = in_active ? s_dat : '0;

    // ------------------------------------------------------------------
    // Routing state machine.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every
        // register samples the pre-edge values and ordering does not matter.
        if (rst) begin
            state <= IDLE;
            sel_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (match0) begin
                            sel_q <= 1'b0;
                            state <= ACTIVE;
                        end else if (match1) begin
                            sel_q <= 1'b1;
                            state <= ACTIVE;
                        end else begin
                            state <= DECERR;
                        end
                    end
                end
                ACTIVE: begin
                    if (!wbm_cyc_i || slave_term || tmo_fire) begin
                        state <= IDLE;
                    end
                end
                DECERR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
